// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - shared types and line helpers for the l1 cache
package l1_cache_pkg;

  localparam int DEF_IDX_BITS = 3;

  typedef logic [127:0]                lc3b_c_line;
  typedef logic [DEF_IDX_BITS-1:0]     lc3b_c_index;
  typedef logic [12-DEF_IDX_BITS-1:0]  lc3b_c_tag;
  typedef logic [3:0]                  lc3b_c_offset;
  typedef logic [15:0]                 lc3b_pmem_addr;
  typedef logic [15:0]                 lc3b_word;
  typedef logic [1:0]                  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } cache_state_t;

  // Merge one lane-aligned CPU word into a line, honouring the byte mask.
  function automatic lc3b_c_line merge_word(input lc3b_c_line line,
                                            input logic [2:0] wsel,
                                            input lc3b_word wdata,
                                            input lc3b_mem_wmask be);
    lc3b_c_line r;
    r = line;
    if (be[0]) r[{wsel, 4'd0} +: 8] = wdata[7:0];
    if (be[1]) r[{wsel, 4'd8} +: 8] = wdata[15:8];
    return r;
  endfunction

  // Pick the 16-bit word addressed by the word-select field.
  function automatic lc3b_word select_word(input lc3b_c_line line,
                                           input logic [2:0] wsel);
    return line[{wsel, 4'd0} +: 16];
  endfunction

endpackage

// File: rtl/l1_cache_control.sv
// rtl/l1_cache_control.sv - miss-handling FSM with strobe and array-load decode
module l1_cache_control
  import l1_cache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mem_read,
  input  logic mem_write,
  input  logic hit,
  input  logic victim_dirty,
  input  logic pmem_resp,
  output logic in_writeback,
  output logic in_fill,
  output logic mem_resp,
  output logic load_word,
  output logic load_line,
  output logic clean_line,
  output logic pmem_read,
  output logic pmem_write
);

  cache_state_t state;
  logic         request;

  assign request = mem_read | mem_write;

  // State register with the pmem strobes registered alongside it so that
  // an asynchronous reset drops them without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (request && !hit) begin
            if (victim_dirty) begin
              state      <= S_WRITEBACK;
              pmem_write <= 1'b1;
            end else begin
              state      <= S_FILL;
              pmem_read  <= 1'b1;
            end
          end
        end
        S_WRITEBACK: begin
          if (pmem_resp) begin
            state      <= S_FILL;
            pmem_write <= 1'b0;
            pmem_read  <= 1'b1;
          end
        end
        S_FILL: begin
          if (pmem_resp) begin
            state     <= S_IDLE;
            pmem_read <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Hit completion and array-load decode; a write wins over a read.
  always_comb begin
    in_writeback = (state == S_WRITEBACK);
    in_fill      = (state == S_FILL);
    mem_resp     = (state == S_IDLE) && request && hit;
    load_word    = (state == S_IDLE) && mem_write && hit;
    load_line    = in_fill && pmem_resp;
    clean_line   = in_writeback && pmem_resp;
  end

endmodule

// File: rtl/l1_cache.sv
// rtl/l1_cache.sv - direct-mapped write-back write-allocate L1 cache
module l1_cache
  import l1_cache_pkg::*;
#(
  parameter int IDX_BITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int LINES    = 1 << IDX_BITS;
  localparam int TAG_BITS = 12 - IDX_BITS;

  logic [IDX_BITS-1:0] index;
  logic [TAG_BITS-1:0] tag;
  logic [2:0]          wsel;
  logic                addr_lsb_unused;

  lc3b_c_line          data_q [LINES];
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;

  lc3b_c_line          line_cur;
  logic [TAG_BITS-1:0] tag_cur;
  logic                hit;
  logic                victim_dirty;

  logic in_writeback;
  logic in_fill;
  logic load_word;
  logic load_line;
  logic clean_line;

  assign index           = mem_address[3+IDX_BITS:4];
  assign tag             = mem_address[15:4+IDX_BITS];
  assign wsel            = mem_address[3:1];
  assign addr_lsb_unused = mem_address[0];

  assign line_cur     = data_q[index];
  assign tag_cur      = tag_q[index];
  assign hit          = valid_q[index] && (tag_cur == tag);
  assign victim_dirty = valid_q[index] && dirty_q[index];

  l1_cache_control u_control (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .hit          (hit),
    .victim_dirty (victim_dirty),
    .pmem_resp    (pmem_resp),
    .in_writeback (in_writeback),
    .in_fill      (in_fill),
    .mem_resp     (mem_resp),
    .load_word    (load_word),
    .load_line    (load_line),
    .clean_line   (clean_line),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write)
  );

  // Line data and tags: no reset, a fill replaces the line, a write hit merges bytes.
  always_ff @(posedge clk) begin
    if (load_line) begin
      data_q[index] <= pmem_rdata;
      tag_q[index]  <= tag;
    end else if (load_word) begin
      data_q[index] <= merge_word(line_cur, wsel, mem_wdata, mem_byte_enable);
    end
  end

  // Valid and dirty bits: cleared by reset so half-serviced lines never appear valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (load_line) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (clean_line) begin
      dirty_q[index] <= 1'b0;
    end else if (load_word) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Read word and memory-side address selection; the fill follows the live CPU address.
  always_comb begin
    mem_rdata    = select_word(line_cur, wsel);
    pmem_wdata   = line_cur;
    pmem_address = 16'h0000;
    if (in_writeback) begin
      pmem_address = {tag_cur, index, 4'b0000};
    end else if (in_fill) begin
      pmem_address = {mem_address[15:4], 4'b0000};
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// tb/tb_l1_cache.sv - directed self-checking bench for l1_cache
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int total = 0;
  int bad   = 0;

  l1_cache dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  // Protocol checks on the CPU side.
  logic [15:0] addr_prev;
  logic        miss_prev;
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_read && mem_write)) else $error("read and write asserted together");
      if (miss_prev && (mem_read || mem_write))
        assert (mem_address == addr_prev) else $error("address changed during miss");
    end
    addr_prev <= mem_address;
    miss_prev <= pmem_read | pmem_write;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] make_line(input logic [15:0] base);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) l[i*16 +: 16] = base + 16'(i);
    return l;
  endfunction

  task automatic hit_access(input string tag, input logic wr, input logic [15:0] addr,
                            input logic [1:0] be, input logic [15:0] wdata,
                            input logic [15:0] exp);
    mem_address     = addr;
    mem_write       = wr;
    mem_read        = !wr;
    mem_byte_enable = be;
    mem_wdata       = wdata;
    #1;
    check({tag, "_resp"}, mem_resp, 1'b1);
    if (!wr) check({tag, "_data"}, mem_rdata, exp);
    check({tag, "_nopmem"}, {pmem_read, pmem_write}, 2'b00);
    tick();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic start_read(input logic [15:0] addr);
    mem_address = addr;
    mem_read    = 1'b1;
    mem_write   = 1'b0;
  endtask

  task automatic give_line(input logic [127:0] line);
    pmem_rdata = line;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
  endtask

  logic [127:0] l1, l2, l3, l4, l5, exp_wb;
  int resp_cnt;

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
    mem_address = 16'h0; mem_wdata = 16'h0; pmem_rdata = '0; pmem_resp = 1'b0;
    tick(); tick();
    check("rst_mem_resp", mem_resp, 1'b0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_addr", pmem_address, 16'h0000);
    rst = 1'b0;
    tick();

    // Cold read miss then fill.
    l1 = make_line(16'h1000);
    l1[31:16] = 16'hBEEF;
    start_read(16'h0132);
    #1 check("cold_miss_resp", mem_resp, 1'b0);
    tick();
    check("cold_pmem_read", pmem_read, 1'b1);
    check("cold_pmem_write", pmem_write, 1'b0);
    check("cold_pmem_addr", pmem_address, 16'h0130);
    tick();
    check("cold_wait_read", pmem_read, 1'b1);
    check("cold_wait_resp", mem_resp, 1'b0);
    give_line(l1);
    check("cold_fill_resp", mem_resp, 1'b1);
    check("cold_fill_data", mem_rdata, 16'hBEEF);
    check("cold_fill_pmem_read", pmem_read, 1'b0);
    tick();
    mem_read = 1'b0;
    hit_access("reread", 1'b0, 16'h0132, 2'b11, 16'h0, 16'hBEEF);

    // Stray pmem_resp in IDLE must not touch the array.
    pmem_rdata = {128{1'b1}};
    give_line({128{1'b1}});
    check("stray_resp_read", pmem_read, 1'b0);
    check("stray_resp_resp", mem_resp, 1'b0);
    hit_access("stray_keep", 1'b0, 16'h0134, 2'b11, 16'h0, 16'h1002);

    // Write hits: word, high byte, low byte.
    hit_access("wr_word", 1'b1, 16'h0132, 2'b11, 16'h1234, 16'h0);
    hit_access("wr_hbyte", 1'b1, 16'h0133, 2'b10, 16'hAB00, 16'h0);
    hit_access("rd_merge", 1'b0, 16'h0132, 2'b11, 16'h0, 16'hAB34);
    hit_access("wr_lbyte", 1'b1, 16'h0134, 2'b01, 16'h00CD, 16'h0);
    hit_access("rd_lbyte", 1'b0, 16'h0134, 2'b11, 16'h0, 16'h10CD);

    // Dirty eviction: writeback then fill.
    exp_wb = l1;
    exp_wb[31:16] = 16'hAB34;
    exp_wb[47:32] = 16'h10CD;
    l2 = make_line(16'h2000);
    start_read(16'h0232);
    #1 check("dirty_miss_resp", mem_resp, 1'b0);
    tick();
    check("wb_pmem_write", pmem_write, 1'b1);
    check("wb_pmem_read", pmem_read, 1'b0);
    check("wb_pmem_addr", pmem_address, 16'h0130);
    check("wb_pmem_wdata", pmem_wdata, exp_wb);
    give_line('0);
    check("wb_then_write", pmem_write, 1'b0);
    check("wb_then_read", pmem_read, 1'b1);
    check("wb_then_addr", pmem_address, 16'h0230);
    give_line(l2);
    check("dirty_fill_resp", mem_resp, 1'b1);
    check("dirty_fill_data", mem_rdata, 16'h2001);
    tick();
    mem_read = 1'b0;

    // Clean eviction: fill only.
    l3 = make_line(16'h4000);
    start_read(16'h0432);
    #1 check("clean_miss_resp", mem_resp, 1'b0);
    tick();
    check("clean_pmem_write", pmem_write, 1'b0);
    check("clean_pmem_read", pmem_read, 1'b1);
    check("clean_pmem_addr", pmem_address, 16'h0430);
    give_line(l3);
    check("clean_fill_resp", mem_resp, 1'b1);
    check("clean_fill_data", mem_rdata, 16'h4001);
    tick();
    mem_read = 1'b0;

    // Fill 0x0130 then stream all eight words back to back.
    l4 = make_line(16'h5000);
    start_read(16'h0130);
    tick();
    check("stream_fill_read", pmem_read, 1'b1);
    check("stream_fill_write", pmem_write, 1'b0);
    give_line(l4);
    resp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      mem_address = 16'h0130 + 16'(2 * i);
      mem_read    = 1'b1;
      #1;
      if (mem_resp) resp_cnt++;
      check($sformatf("stream_data_%0d", i), mem_rdata, 16'h5000 + 16'(i));
      @(posedge clk);
      #1;
    end
    mem_read = 1'b0;
    check("stream_resp_count", resp_cnt, 8);

    // Reset during FILL with pmem_resp withheld.
    l5 = make_line(16'h6000);
    start_read(16'h0632);
    tick();
    check("abort_pmem_read", pmem_read, 1'b1);
    check("abort_pmem_addr", pmem_address, 16'h0630);
    #2 rst = 1'b1;
    #1;
    check("abort_async_read", pmem_read, 1'b0);
    check("abort_async_addr", pmem_address, 16'h0000);
    tick();
    rst = 1'b0;
    #1 check("abort_remiss_resp", mem_resp, 1'b0);
    tick();
    check("abort_refill_read", pmem_read, 1'b1);
    check("abort_refill_addr", pmem_address, 16'h0630);
    give_line(l5);
    check("abort_fill_resp", mem_resp, 1'b1);
    check("abort_fill_data", mem_rdata, 16'h6001);
    tick();
    mem_read = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
